// File: rtl/bsg_wormhole_link_framing_monitor.sv
// rtl/bsg_wormhole_link_framing_monitor.sv - pass-through wormhole link stage with framing, count and stall monitoring
// Flits traverse a 2-entry elastic buffer untouched; framing is tracked on the input side.
module bsg_wormhole_link_framing_monitor #(
  parameter int flit_width_p  = 32,
  parameter int cord_width_p  = 5,
  parameter int len_width_p   = 3,
  parameter int max_len_p     = 7,
  parameter int stall_limit_p = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [flit_width_p-1:0] data_i,
  output logic                    ready_and_o,
  output logic                    v_o,
  output logic [flit_width_p-1:0] data_o,
  input  logic                    ready_and_i,
  input  logic                    clear_i,
  output logic                    in_packet_o,
  output logic [31:0]             flit_count_o,
  output logic [31:0]             pkt_count_o,
  output logic                    len_err_o,
  output logic                    stall_o
);

  localparam int stall_w_lp = $clog2(stall_limit_p + 1);
  localparam logic [len_width_p-1:0] max_len_lp   = len_width_p'(max_len_p);
  localparam logic [stall_w_lp-1:0]  stall_lim_lp = stall_w_lp'(stall_limit_p);

  typedef enum logic {
    e_hdr,
    e_body
  } state_e;

  logic [flit_width_p-1:0] mem_r [2];
  logic                    wptr_r, rptr_r;
  logic [1:0]              count_r;
  logic                    enq, deq;

  state_e                  state_r, state_n;
  logic [len_width_p-1:0]  rem_r, rem_n;
  logic [len_width_p-1:0]  hdr_len;
  logic                    pkt_done, hdr_len_err;

  logic [31:0]             flit_count_r, pkt_count_r;
  logic                    len_err_r, stall_r;
  logic [stall_w_lp-1:0]   stall_cnt_r, stall_cnt_n;

  // Ready depends only on occupancy, so a full buffer never turns ready on a same-cycle dequeue.
  assign ready_and_o = (count_r != 2'd2);
  assign v_o         = (count_r != 2'd0);
  assign data_o      = mem_r[rptr_r];
  assign enq         = v_i & ready_and_o;
  assign deq         = v_o & ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      unique case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  assign hdr_len     = data_i[cord_width_p +: len_width_p];
  assign in_packet_o = (state_r == e_body);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_hdr;
      rem_r   <= '0;
    end else begin
      state_r <= state_n;
      rem_r   <= rem_n;
    end
  end

  // An oversize header is flagged but the declared len is still followed.
  always_comb begin
    state_n     = state_r;
    rem_n       = rem_r;
    pkt_done    = 1'b0;
    hdr_len_err = 1'b0;
    if (enq) begin
      unique case (state_r)
        e_hdr: begin
          hdr_len_err = (hdr_len > max_len_lp);
          if (hdr_len == '0) begin
            pkt_done = 1'b1;
          end else begin
            rem_n   = hdr_len;
            state_n = e_body;
          end
        end
        e_body: begin
          rem_n = rem_r - 1'b1;
          if (rem_r == len_width_p'(1)) begin
            pkt_done = 1'b1;
            state_n  = e_hdr;
          end
        end
        default: state_n = e_hdr;
      endcase
    end
  end

  always_comb begin
    stall_cnt_n = '0;
    if (v_o & ~ready_and_i) begin
      stall_cnt_n = (stall_cnt_r == stall_lim_lp) ? stall_cnt_r : stall_cnt_r + 1'b1;
    end
  end

  // Clear takes priority over any same-cycle increment or flag set.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      flit_count_r <= '0;
      pkt_count_r  <= '0;
      len_err_r    <= 1'b0;
      stall_r      <= 1'b0;
      stall_cnt_r  <= '0;
    end else if (clear_i) begin
      flit_count_r <= '0;
      pkt_count_r  <= '0;
      len_err_r    <= 1'b0;
      stall_r      <= 1'b0;
      stall_cnt_r  <= '0;
    end else begin
      if (enq)      flit_count_r <= flit_count_r + 32'd1;
      if (pkt_done) pkt_count_r  <= pkt_count_r + 32'd1;
      len_err_r   <= len_err_r | hdr_len_err;
      stall_r     <= stall_r | (stall_cnt_n == stall_lim_lp);
      stall_cnt_r <= stall_cnt_n;
    end
  end

  assign flit_count_o = flit_count_r;
  assign pkt_count_o  = pkt_count_r;
  assign len_err_o    = len_err_r;
  assign stall_o      = stall_r;

endmodule

// File: tb/tb_bsg_wormhole_link_framing_monitor.sv
// tb/tb_bsg_wormhole_link_framing_monitor.sv - directed self-checking bench for the link framing monitor
module tb_bsg_wormhole_link_framing_monitor;

  localparam int fw_lp = 32;

  logic              clk = 1'b0;
  logic              reset_i, v_i, ready_and_i, clear_i;
  logic [fw_lp-1:0]  data_i, data_o;
  logic              ready_and_o, v_o, in_packet_o, len_err_o, stall_o;
  logic [31:0]       flit_count_o, pkt_count_o;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_out = 0;
  bit                inpkt_seen = 0;
  logic [31:0]       exp_q [$];

  bsg_wormhole_link_framing_monitor #(
    .flit_width_p(32), .cord_width_p(5), .len_width_p(3), .max_len_p(5), .stall_limit_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_and_o(ready_and_o),
    .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i), .clear_i(clear_i),
    .in_packet_o(in_packet_o), .flit_count_o(flit_count_o), .pkt_count_o(pkt_count_o),
    .len_err_o(len_err_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [2:0] len, input logic [23:0] id);
    return {id, len, 5'd3};
  endfunction

  function automatic logic [31:0] body(input logic [23:0] id);
    return {8'hb0, id};
  endfunction

  // Inputs only change 1 time unit after a rising edge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (v_o && ready_and_i) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else check("data_o", data_o, exp_q.pop_front());
        n_out++;
      end
      if (v_i && ready_and_o) exp_q.push_back(data_i);
      if (in_packet_o) inpkt_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok     = 1'b0;
    v_i    = 1'b1;
    data_i = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_and_o) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    v_i = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  int base, acc;
  bit a;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; ready_and_i = 1'b1; clear_i = 1'b0;
    #12 reset_i = 1'b0;
    tick();
    check("rst_v_o", v_o, 0);
    check("rst_ready", ready_and_o, 1);
    check("rst_in_packet", in_packet_o, 0);
    check("rst_flits", flit_count_o, 0);
    check("rst_pkts", pkt_count_o, 0);
    check("rst_len_err", len_err_o, 0);
    check("rst_stall", stall_o, 0);

    // back-to-back len=3 packets
    for (int p = 0; p < 4; p++) begin
      send(hdr(3, 24'h100 + 24'(p)));
      if (p == 0) check("first_v_o_latency", v_o, 1);
      for (int b = 0; b < 3; b++) send(body(24'h200 + 24'(p * 4 + b)));
    end
    repeat (3) tick();
    check("t1_flits", flit_count_o, 16);
    check("t1_pkts", pkt_count_o, 4);
    check("t1_out", n_out, 16);
    check("t1_len_err", len_err_o, 0);
    check("t1_in_packet", in_packet_o, 0);

    // header-only packets
    clear_pulse();
    check("clr_flits", flit_count_o, 0);
    check("clr_pkts", pkt_count_o, 0);
    inpkt_seen = 1'b0;
    for (int p = 0; p < 5; p++) send(hdr(0, 24'h300 + 24'(p)));
    repeat (2) tick();
    check("t2_pkts", pkt_count_o, 5);
    check("t2_flits", flit_count_o, 5);
    check("t2_inpkt_seen", 32'(inpkt_seen), 0);

    // backpressure and stall
    ready_and_i = 1'b0;
    base = n_out;
    acc = 0;
    v_i = 1'b1;
    data_i = hdr(0, 24'h400);
    repeat (5) begin
      @(negedge clk);
      a = ready_and_o;
      tick();
      if (a) begin
        acc++;
        data_i = hdr(0, 24'h400 + 24'(acc));
      end
    end
    v_i = 1'b0;
    check("t3_accepts", acc, 2);
    check("t3_ready_full", ready_and_o, 0);
    check("t3_v_o", v_o, 1);
    clear_pulse();
    repeat (7) tick();
    check("t3_stall_at_7", stall_o, 0);
    tick();
    check("t3_stall_at_8", stall_o, 1);
    ready_and_i = 1'b1;
    repeat (4) tick();
    check("t3_drained", n_out - base, 2);
    check("t3_ready_back", ready_and_o, 1);
    check("t3_stall_sticky", stall_o, 1);

    // oversize header (max_len_p=5, len=6)
    clear_pulse();
    check("t4_stall_cleared", stall_o, 0);
    base = n_out;
    send(hdr(6, 24'h500));
    check("t4_len_err", len_err_o, 1);
    check("t4_in_packet", in_packet_o, 1);
    for (int b = 0; b < 5; b++) send(body(24'h510 + 24'(b)));
    check("t4_in_packet_5", in_packet_o, 1);
    send(body(24'h51f));
    check("t4_in_packet_end", in_packet_o, 0);
    check("t4_pkts", pkt_count_o, 1);
    repeat (3) tick();
    check("t4_flits", flit_count_o, 7);
    check("t4_out", n_out - base, 7);

    // async reset mid-body
    ready_and_i = 1'b0;
    send(hdr(3, 24'h600));
    send(body(24'h601));
    check("t5_in_packet", in_packet_o, 1);
    check("t5_v_o", v_o, 1);
    #2 reset_i = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_v_o", v_o, 0);
    check("t5_rst_in_packet", in_packet_o, 0);
    check("t5_rst_flits", flit_count_o, 0);
    check("t5_rst_pkts", pkt_count_o, 0);
    check("t5_rst_len_err", len_err_o, 0);
    check("t5_rst_stall", stall_o, 0);
    #3 reset_i = 1'b0;
    ready_and_i = 1'b1;
    tick();
    check("t5_ready", ready_and_o, 1);
    send(hdr(0, 24'h602));
    check("t5_hdr_pkts", pkt_count_o, 1);
    check("t5_hdr_in_packet", in_packet_o, 0);

    // clear on the final body flit
    send(hdr(2, 24'h700));
    send(body(24'h701));
    clear_i = 1'b1;
    send(body(24'h702));
    clear_i = 1'b0;
    check("t6_pkts", pkt_count_o, 0);
    check("t6_flits", flit_count_o, 0);
    check("t6_in_packet", in_packet_o, 0);
    send(hdr(0, 24'h703));
    check("t6_next_pkts", pkt_count_o, 1);
    check("t6_next_flits", flit_count_o, 1);

    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
